// File: rtl/leap_pkg.sv
// rtl/leap_pkg.sv - shared op encoding and default parameters for the leap generator
// Purpose: op select enum used by leap_alu and leap_gen, plus default parameter values.
// Ports: none (package).
package leap_pkg;

    typedef enum logic [2:0] {
        OP_DBL    = 3'd0,
        OP_ADDH   = 3'd1,
        OP_SUBK   = 3'd2,
        OP_ADDK   = 3'd3,
        OP_HALF   = 3'd4,
        OP_HOLD   = 3'd5,
        OP_RELOAD = 3'd6,
        OP_TRIP   = 3'd7
    } op_e;

    localparam int DEF_WIDTH = 128;
    localparam int DEF_SEED  = 17;
    localparam int DEF_K     = 3;
    localparam int DEF_SAT   = 0;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/leap_alu.sv
// rtl/leap_alu.sv - combinational next-state arithmetic with wrap or saturate
// Purpose: computes the op result in WIDTH+2 bits so DBL/ADDH/TRIP carries are
//          never lost, then detects overflow/underflow and wraps or clamps.
// Ports:
//   s_i          current state
//   op_i         operation select
//   res_o        WIDTH-bit result after wrap/saturate
//   range_evt_o  overflow or underflow happened for this op
module leap_alu
    import leap_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEED  = DEF_SEED,
    parameter int K     = DEF_K,
    parameter int SAT   = DEF_SAT
) (
    input  logic [WIDTH-1:0] s_i,
    input  op_e              op_i,
    output logic [WIDTH-1:0] res_o,
    output logic             range_evt_o
);

    localparam logic [WIDTH+1:0] KX    = (WIDTH+2)'(K);
    localparam logic [WIDTH+1:0] SEEDX = (WIDTH+2)'(SEED);

    logic [WIDTH+1:0] ext;
    logic [WIDTH+1:0] wide;
    logic             under;
    logic             over;

    assign ext = {2'b00, s_i};

    always_comb begin
        wide = ext;
        unique case (op_i)
            OP_DBL:    wide = ext + ext;
            OP_ADDH:   wide = ext + (ext >> 1);
            OP_SUBK:   wide = ext - KX;
            OP_ADDK:   wide = ext + KX;
            OP_HALF:   wide = ext >> 1;
            OP_HOLD:   wide = ext;
            OP_RELOAD: wide = SEEDX;
            OP_TRIP:   wide = ext + ext + ext;
            default:   wide = ext;
        endcase
    end

    // A SUBK borrow also sets the top bits of wide, so it must not be
    // mistaken for an overflow.
    assign under = (op_i == OP_SUBK) && (ext < KX);
    assign over  = !under && (wide[WIDTH+1:WIDTH] != 2'b00);

    assign range_evt_o = under | over;

    always_comb begin
        res_o = wide[WIDTH-1:0];
        if (SAT != 0) begin
            if (over) begin
                res_o = '1;
            end else if (under) begin
                res_o = '0;
            end
        end
    end

endmodule

// File: rtl/leap_gen.sv
// rtl/leap_gen.sv - parametrised leap state machine with target/found tracking
// Purpose: holds the state register, saturating step counter, sticky overflow,
//          loadable target and sticky found detection with first-hit step capture.
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   valid, op    execute op this cycle
//   tgt_load     load tgt_in as the new target (clears found)
//   tgt_in       new target value
//   state        current state
//   steps        accepted ops since reset/RELOAD (saturating)
//   found        state has matched target since last clear
//   found_steps  steps value at first match
//   ovf          sticky overflow/underflow
module leap_gen
    import leap_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEED  = DEF_SEED,
    parameter int K     = DEF_K,
    parameter int SAT   = DEF_SAT,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [2:0]       op,
    input  logic             tgt_load,
    input  logic [WIDTH-1:0] tgt_in,
    output logic [WIDTH-1:0] state,
    output logic [CNT_W-1:0] steps,
    output logic             found,
    output logic [CNT_W-1:0] found_steps,
    output logic             ovf
);

    logic [WIDTH-1:0] state_q, state_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic             found_q, found_d;
    logic [CNT_W-1:0] fsteps_q, fsteps_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_evt;
    op_e              op_sel;

    logic [WIDTH-1:0] tgt_eff;
    logic             found_eff;
    logic [CNT_W-1:0] fsteps_eff;

    assign op_sel = op_e'(op);

    leap_alu #(
        .WIDTH (WIDTH),
        .SEED  (SEED),
        .K     (K),
        .SAT   (SAT)
    ) u_alu (
        .s_i         (state_q),
        .op_i        (op_sel),
        .res_o       (alu_res),
        .range_evt_o (alu_evt)
    );

    always_comb begin
        state_d = state_q;
        steps_d = steps_q;
        ovf_d   = ovf_q;
        if (valid) begin
            state_d = alu_res;
            if (op_sel == OP_RELOAD) begin
                steps_d = '0;
                ovf_d   = 1'b0;
            end else begin
                steps_d = (&steps_q) ? steps_q : steps_q + CNT_W'(1);
                ovf_d   = ovf_q | alu_evt;
            end
        end
    end

    // A target load wipes the previous hit before the compare, so a load that
    // matches the freshly computed state records a new hit in the same edge.
    always_comb begin
        tgt_eff    = tgt_load ? tgt_in : tgt_q;
        found_eff  = tgt_load ? 1'b0   : found_q;
        fsteps_eff = tgt_load ? '0     : fsteps_q;
        tgt_d      = tgt_eff;
        found_d    = found_eff;
        fsteps_d   = fsteps_eff;
        if ((state_d == tgt_eff) && !found_eff) begin
            found_d  = 1'b1;
            fsteps_d = steps_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= WIDTH'(SEED);
            steps_q  <= '0;
            tgt_q    <= '0;
            found_q  <= 1'b0;
            fsteps_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            steps_q  <= steps_d;
            tgt_q    <= tgt_d;
            found_q  <= found_d;
            fsteps_q <= fsteps_d;
            ovf_q    <= ovf_d;
        end
    end

    assign state       = state_q;
    assign steps       = steps_q;
    assign found       = found_q;
    assign found_steps = fsteps_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_leap_gen.sv
// tb/tb_leap_gen.sv - directed table-driven bench for leap_gen
module tb_leap_gen;
    import leap_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic [2:0]   op;
    logic         tgt_load;
    logic [127:0] tgt_in;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // default parameters
    logic [127:0] d_state;
    logic [15:0]  d_steps, d_fs;
    logic         d_found, d_ovf;
    // WIDTH=8 SAT=1 / SAT=0
    logic [7:0]   s8_state, w8_state;
    logic [15:0]  s8_steps, s8_fs, w8_steps, w8_fs;
    logic         s8_found, s8_ovf, w8_found, w8_ovf;
    // WIDTH=8 CNT_W=2
    logic [7:0]   c2_state;
    logic [1:0]   c2_steps, c2_fs;
    logic         c2_found, c2_ovf;
    // WIDTH=8 SEED=1, SAT=1 / SAT=0
    logic [7:0]   b1_state, b0_state;
    logic [15:0]  b1_steps, b1_fs, b0_steps, b0_fs;
    logic         b1_found, b1_ovf, b0_found, b0_ovf;

    leap_gen u_def (
        .clk(clk), .rst(rst), .valid(valid), .op(op), .tgt_load(tgt_load), .tgt_in(tgt_in),
        .state(d_state), .steps(d_steps), .found(d_found), .found_steps(d_fs), .ovf(d_ovf)
    );
    leap_gen #(.WIDTH(8), .SAT(1)) u_s8 (
        .clk(clk), .rst(rst), .valid(valid), .op(op), .tgt_load(tgt_load), .tgt_in(tgt_in[7:0]),
        .state(s8_state), .steps(s8_steps), .found(s8_found), .found_steps(s8_fs), .ovf(s8_ovf)
    );
    leap_gen #(.WIDTH(8), .SAT(0)) u_w8 (
        .clk(clk), .rst(rst), .valid(valid), .op(op), .tgt_load(tgt_load), .tgt_in(tgt_in[7:0]),
        .state(w8_state), .steps(w8_steps), .found(w8_found), .found_steps(w8_fs), .ovf(w8_ovf)
    );
    leap_gen #(.WIDTH(8), .CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .valid(valid), .op(op), .tgt_load(tgt_load), .tgt_in(tgt_in[7:0]),
        .state(c2_state), .steps(c2_steps), .found(c2_found), .found_steps(c2_fs), .ovf(c2_ovf)
    );
    leap_gen #(.WIDTH(8), .SEED(1), .SAT(1)) u_b1 (
        .clk(clk), .rst(rst), .valid(valid), .op(op), .tgt_load(tgt_load), .tgt_in(tgt_in[7:0]),
        .state(b1_state), .steps(b1_steps), .found(b1_found), .found_steps(b1_fs), .ovf(b1_ovf)
    );
    leap_gen #(.WIDTH(8), .SEED(1), .SAT(0)) u_b0 (
        .clk(clk), .rst(rst), .valid(valid), .op(op), .tgt_load(tgt_load), .tgt_in(tgt_in[7:0]),
        .state(b0_state), .steps(b0_steps), .found(b0_found), .found_steps(b0_fs), .ovf(b0_ovf)
    );

    typedef struct {
        logic         v;
        op_e          o;
        logic         ld;
        logic [127:0] tin;
        logic [127:0] e_state;
        logic [15:0]  e_steps;
        logic         e_found;
        logic [15:0]  e_fs;
        logic         e_ovf;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic v, input op_e o, input logic ld, input logic [127:0] tin);
        @(negedge clk);
        valid    = v;
        op       = o;
        tgt_load = ld;
        tgt_in   = tin;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        valid    = 1'b0;
        tgt_load = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] s8_exp[4];
        logic [7:0] w8_exp[4];
        logic [1:0] c2_exp[5];

        tv[0]  = '{1'b0, OP_DBL,    1'b1, 128'h20, 128'd17,  16'd0, 1'b0, 16'd0, 1'b0};
        tv[1]  = '{1'b1, OP_HALF,   1'b0, 128'h0,  128'd8,   16'd1, 1'b0, 16'd0, 1'b0};
        tv[2]  = '{1'b1, OP_DBL,    1'b0, 128'h0,  128'd16,  16'd2, 1'b0, 16'd0, 1'b0};
        tv[3]  = '{1'b1, OP_DBL,    1'b0, 128'h0,  128'd32,  16'd3, 1'b1, 16'd3, 1'b0};
        tv[4]  = '{1'b1, OP_ADDK,   1'b0, 128'h0,  128'd35,  16'd4, 1'b1, 16'd3, 1'b0};
        tv[5]  = '{1'b1, OP_SUBK,   1'b0, 128'h0,  128'd32,  16'd5, 1'b1, 16'd3, 1'b0};
        tv[6]  = '{1'b1, OP_ADDH,   1'b0, 128'h0,  128'd48,  16'd6, 1'b1, 16'd3, 1'b0};
        tv[7]  = '{1'b1, OP_TRIP,   1'b0, 128'h0,  128'd144, 16'd7, 1'b1, 16'd3, 1'b0};
        tv[8]  = '{1'b1, OP_HOLD,   1'b0, 128'h0,  128'd144, 16'd8, 1'b1, 16'd3, 1'b0};
        tv[9]  = '{1'b1, OP_RELOAD, 1'b0, 128'h0,  128'd17,  16'd0, 1'b1, 16'd3, 1'b0};
        tv[10] = '{1'b0, OP_DBL,    1'b1, 128'd17, 128'd17,  16'd0, 1'b1, 16'd0, 1'b0};
        tv[11] = '{1'b1, OP_ADDK,   1'b1, 128'd20, 128'd20,  16'd1, 1'b1, 16'd1, 1'b0};
        tv[12] = '{1'b0, OP_DBL,    1'b1, 128'd5,  128'd20,  16'd1, 1'b0, 16'd0, 1'b0};

        s8_exp = '{8'd34, 8'd68, 8'd136, 8'd255};
        w8_exp = '{8'd34, 8'd68, 8'd136, 8'd16};
        c2_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        rst = 1'b0; valid = 1'b0; op = 3'd0; tgt_load = 1'b0; tgt_in = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_state", d_state, 128'd17);
        chk("rst_steps", 128'(d_steps), 128'd0);
        chk("rst_found", 128'(d_found), 128'd0);
        chk("rst_fsteps", 128'(d_fs), 128'd0);
        chk("rst_ovf", 128'(d_ovf), 128'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            apply(tv[i].v, tv[i].o, tv[i].ld, tv[i].tin);
            chk($sformatf("tv%0d_state", i), d_state, tv[i].e_state);
            chk($sformatf("tv%0d_steps", i), 128'(d_steps), 128'(tv[i].e_steps));
            chk($sformatf("tv%0d_found", i), 128'(d_found), 128'(tv[i].e_found));
            chk($sformatf("tv%0d_fsteps", i), 128'(d_fs), 128'(tv[i].e_fs));
            chk($sformatf("tv%0d_ovf", i), 128'(d_ovf), 128'(tv[i].e_ovf));
        end

        // saturate vs wrap on repeated doubling in 8 bits
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, OP_DBL, 1'b0, 128'h0);
            chk($sformatf("sat_state%0d", i), 128'(s8_state), 128'(s8_exp[i]));
            chk($sformatf("wrap_state%0d", i), 128'(w8_state), 128'(w8_exp[i]));
            chk($sformatf("sat_ovf%0d", i), 128'(s8_ovf), (i == 3) ? 128'd1 : 128'd0);
            chk($sformatf("wrap_ovf%0d", i), 128'(w8_ovf), (i == 3) ? 128'd1 : 128'd0);
        end

        // step counter saturation, then RELOAD
        do_reset();
        apply(1'b0, OP_HOLD, 1'b1, 128'd17);
        chk("c2_found_load", 128'(c2_found), 128'd1);
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, OP_HOLD, 1'b0, 128'h0);
            chk($sformatf("c2_steps%0d", i), 128'(c2_steps), 128'(c2_exp[i]));
        end
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, OP_DBL, 1'b0, 128'h0);
        end
        chk("c2_state_wrap", 128'(c2_state), 128'd16);
        chk("c2_ovf_set", 128'(c2_ovf), 128'd1);
        apply(1'b1, OP_RELOAD, 1'b0, 128'h0);
        chk("c2_reload_state", 128'(c2_state), 128'd17);
        chk("c2_reload_steps", 128'(c2_steps), 128'd0);
        chk("c2_reload_ovf", 128'(c2_ovf), 128'd0);
        chk("c2_reload_found", 128'(c2_found), 128'd1);
        chk("c2_reload_fsteps", 128'(c2_fs), 128'd0);

        // reset arriving together with an op
        do_reset();
        apply(1'b1, OP_DBL, 1'b1, 128'd34);
        chk("mid_state", d_state, 128'd34);
        chk("mid_found", 128'(d_found), 128'd1);
        chk("mid_fsteps", 128'(d_fs), 128'd1);
        @(negedge clk);
        rst = 1'b0; valid = 1'b1; op = OP_DBL; tgt_load = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_state", d_state, 128'd17);
        chk("midrst_steps", 128'(d_steps), 128'd0);
        chk("midrst_found", 128'(d_found), 128'd0);
        chk("midrst_fsteps", 128'(d_fs), 128'd0);
        chk("midrst_ovf", 128'(d_ovf), 128'd0);

        // SUBK underflow from SEED=1; target reset to 0 makes the clamp a hit
        @(negedge clk);
        rst = 1'b1; valid = 1'b1; op = OP_SUBK; tgt_load = 1'b0;
        @(posedge clk);
        #1;
        chk("subk_sat_state", 128'(b1_state), 128'd0);
        chk("subk_sat_ovf", 128'(b1_ovf), 128'd1);
        chk("subk_sat_found", 128'(b1_found), 128'd1);
        chk("subk_sat_fsteps", 128'(b1_fs), 128'd1);
        chk("subk_wrap_state", 128'(b0_state), 128'd254);
        chk("subk_wrap_ovf", 128'(b0_ovf), 128'd1);
        chk("subk_wrap_found", 128'(b0_found), 128'd0);
        chk("subk_def_state", d_state, 128'd14);

        @(negedge clk);
        valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
